// File: rtl/iob_fifo_rd_stream.sv
// Moves a start-requested number of words from a synchronous FIFO read port onto a
// valid/ready stream, through a 2-entry register buffer so stream outputs come from flops.
module iob_fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_r_data,
  input  logic              fifo_r_empty,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  issued_inc;
  logic              inflight;
  logic              inflight_last;
  logic              issue_last;

  // Second buffer entry; the head entry is the m_tdata/m_tvalid/m_tlast flops.
  logic              v1;
  logic [DATA_W-1:0] data1;
  logic              last1;

  logic              push;
  logic              pop;
  logic [2:0]        occ_next;
  logic              room;

  always_comb begin
    pop        = m_tvalid & m_tready;
    push       = inflight;
    issued_inc = issued + LEN_W'(1);
    issue_last = (issued_inc == len_q);
    // Projected occupancy once the outstanding read lands; keeps the buffer at <= 2.
    occ_next   = 3'(m_tvalid) + 3'(v1) + 3'(inflight) - 3'(pop);
    room       = (occ_next < 3'd2);
    fifo_r_en  = (state == RUN) & ~fifo_r_empty & (issued < len_q) & room;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      issued        <= '0;
      count         <= '0;
      done          <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= fifo_r_en;
      inflight_last <= fifo_r_en & issue_last;
      if (fifo_r_en) begin
        issued <= issued_inc;
      end
      if (pop && (count != len_q)) begin
        count <= count + LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state  <= RUN;
              len_q  <= len;
              count  <= '0;
              issued <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fifo_r_en && issue_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_tlast) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      v1       <= 1'b0;
      data1    <= '0;
      last1    <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!m_tvalid) begin
            m_tvalid <= 1'b1;
            m_tdata  <= fifo_r_data;
            m_tlast  <= inflight_last;
          end else begin
            v1    <= 1'b1;
            data1 <= fifo_r_data;
            last1 <= inflight_last;
          end
        end
        2'b01: begin
          m_tvalid <= v1;
          m_tdata  <= data1;
          m_tlast  <= last1;
          v1       <= 1'b0;
          last1    <= 1'b0;
        end
        2'b11: begin
          if (v1) begin
            m_tdata <= data1;
            m_tlast <= last1;
            data1   <= fifo_r_data;
            last1   <= inflight_last;
          end else begin
            m_tdata <= fifo_r_data;
            m_tlast <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
